// File: rtl/axis_chan_deserial_pkg.sv
// Shared types and helpers for the channel deserializer.
//   align_e      : classification of an accepted beat's tlast against the
//                  channel counter.
//   count_width  : width of the channel index counter for a channel count.
package axis_chan_deserial_pkg;

  typedef enum logic [1:0] {
    ALIGN_OK,          // tlast agrees with the channel index
    ALIGN_EARLY_LAST,  // tlast before the final channel: word dropped
    ALIGN_LATE_LAST    // final channel without tlast: word still emitted
  } align_e;

  function automatic int unsigned count_width(input int unsigned num_channels);
    return (num_channels <= 2) ? 1 : $clog2(num_channels);
  endfunction

endpackage

// File: rtl/axis_chan_deserial_if.sv
// Stream bundle for the channel deserializer.
//   s_axis_* : narrow per-channel input stream (CHANNEL_WIDTH data + tlast)
//   m_axis_* : wide packed output stream (NUM_CHANNELS*CHANNEL_WIDTH data)
//   slave    : deserializer side (consumes s_axis, produces m_axis)
//   master   : environment side (produces s_axis, consumes m_axis)
interface axis_chan_deserial_if #(
  parameter int unsigned NUM_CHANNELS  = 4,
  parameter int unsigned CHANNEL_WIDTH = 64
);
  localparam int unsigned DATA_WIDTH = CHANNEL_WIDTH * NUM_CHANNELS;

  logic                     s_axis_tvalid;
  logic                     s_axis_tready;
  logic [CHANNEL_WIDTH-1:0] s_axis_tdata;
  logic                     s_axis_tlast;

  logic                     m_axis_tvalid;
  logic                     m_axis_tready;
  logic [DATA_WIDTH-1:0]    m_axis_tdata;

  modport slave (
    input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tdata
  );

  modport master (
    output s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tdata
  );

endinterface

// File: rtl/axis_chan_deserial_counter.sv
// Bounded up-counter used as the channel index.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset to LOWER
//   ena   : advance by one
//   count : current value, LOWER..UPPER; at UPPER it wraps to LOWER when
//           WRAPAROUND is nonzero, otherwise it saturates
module axis_chan_deserial_counter #(
  parameter int unsigned WIDTH      = 2,
  parameter int unsigned LOWER      = 0,
  parameter int unsigned UPPER      = 3,
  parameter int unsigned WRAPAROUND = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (ena) begin
      if (count_q == WIDTH'(UPPER)) begin
        count_d = (WRAPAROUND != 0) ? WIDTH'(LOWER) : count_q;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= WIDTH'(LOWER);
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/axis_chan_deserial.sv
// Channel deserializer: packs NUM_CHANNELS consecutive CHANNEL_WIDTH beats
// (channel 0 first, tlast on the final channel) into one wide word with
// channel n at [n*CHANNEL_WIDTH +: CHANNEL_WIDTH].
//   clk, rst_n : clock and synchronous active-low reset
//   axis       : s_axis input stream, m_axis packed output stream
//   err_align  : one-cycle pulse after a beat whose tlast disagrees with
//                the channel index
module axis_chan_deserial
  import axis_chan_deserial_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS  = 4,
  parameter int unsigned CHANNEL_WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  axis_chan_deserial_if.slave      axis,
  output logic                     err_align
);

  localparam int unsigned DATA_WIDTH  = CHANNEL_WIDTH * NUM_CHANNELS;
  localparam int unsigned COUNT_WIDTH = count_width(NUM_CHANNELS);
  localparam int unsigned LAST_CH     = NUM_CHANNELS - 1;

  logic [COUNT_WIDTH-1:0]   count;
  logic                     at_last;
  logic                     s_ready;
  logic                     s_frame;
  logic                     m_frame;
  logic                     count_clr;
  align_e                   align;

  // The final channel bypasses the lanes straight into the output word.
  logic [CHANNEL_WIDTH-1:0] lanes_q [0:LAST_CH-1];
  logic [CHANNEL_WIDTH-1:0] lanes_d [0:LAST_CH-1];
  logic                     m_tvalid_q, m_tvalid_d;
  logic [DATA_WIDTH-1:0]    m_tdata_q,  m_tdata_d;
  logic                     err_q,      err_d;
  logic [DATA_WIDTH-1:0]    pack_word;
  logic [CHANNEL_WIDTH-1:0] m_chan_view [0:NUM_CHANNELS-1];

  assign at_last = (count == COUNT_WIDTH'(LAST_CH));
  // Stall only the final beat, and only while an unconsumed word is held.
  assign s_ready = ~at_last | ~m_tvalid_q | axis.m_axis_tready;
  assign s_frame = axis.s_axis_tvalid & s_ready;
  assign m_frame = m_tvalid_q & axis.m_axis_tready;

  always_comb begin
    align = ALIGN_OK;
    if (s_frame) begin
      if (axis.s_axis_tlast && !at_last)      align = ALIGN_EARLY_LAST;
      else if (!axis.s_axis_tlast && at_last) align = ALIGN_LATE_LAST;
    end
  end

  assign count_clr = ~rst_n | (align == ALIGN_EARLY_LAST);

  axis_chan_deserial_counter #(
    .WIDTH      (COUNT_WIDTH),
    .LOWER      (0),
    .UPPER      (LAST_CH),
    .WRAPAROUND (1)
  ) u_count (
    .clk   (clk),
    .rst   (count_clr),
    .ena   (s_frame),
    .count (count)
  );

  for (genvar g = 0; g < LAST_CH; g++) begin : g_pack
    assign pack_word[g*CHANNEL_WIDTH +: CHANNEL_WIDTH] = lanes_q[g];
  end
  assign pack_word[LAST_CH*CHANNEL_WIDTH +: CHANNEL_WIDTH] = axis.s_axis_tdata;

  always_comb begin
    lanes_d    = lanes_q;
    m_tvalid_d = m_tvalid_q;
    m_tdata_d  = m_tdata_q;
    err_d      = (align != ALIGN_OK);

    // Index compare keeps the lane write in range for any channel count.
    if (s_frame && !at_last) begin
      for (int unsigned i = 0; i < LAST_CH; i++) begin
        if (count == COUNT_WIDTH'(i)) lanes_d[i] = axis.s_axis_tdata;
      end
    end

    // A load on the same cycle as a consume replaces the word without a bubble.
    if (s_frame && at_last) begin
      m_tvalid_d = 1'b1;
      m_tdata_d  = pack_word;
    end else if (m_frame) begin
      m_tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lanes_q    <= '{default: '0};
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      lanes_q    <= lanes_d;
      m_tvalid_q <= m_tvalid_d;
      m_tdata_q  <= m_tdata_d;
      err_q      <= err_d;
    end
  end

  // Per-channel view of the output word, handy in waveforms.
  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_view
    assign m_chan_view[g] = m_tdata_q[g*CHANNEL_WIDTH +: CHANNEL_WIDTH];
    assign axis.m_axis_tdata[g*CHANNEL_WIDTH +: CHANNEL_WIDTH] = m_chan_view[g];
  end

  assign axis.s_axis_tready = s_ready;
  assign axis.m_axis_tvalid = m_tvalid_q;
  assign err_align          = err_q;

endmodule

// File: tb/tb_axis_chan_deserial.sv
module tb_axis_chan_deserial;

  localparam int unsigned NC = 4;
  localparam int unsigned CW = 64;
  localparam int unsigned DW = NC * CW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err_align;

  axis_chan_deserial_if #(.NUM_CHANNELS(NC), .CHANNEL_WIDTH(CW)) bus ();

  axis_chan_deserial #(.NUM_CHANNELS(NC), .CHANNEL_WIDTH(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .axis      (bus),
    .err_align (err_align)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int exp_err = 0;
  int seen_err = 0;
  int stall_cnt = 0;
  bit mon_en = 1'b0;
  logic stall_prev = 1'b0;
  logic err_prev = 1'b0;
  logic [DW-1:0] stall_data;
  logic [DW-1:0] exp_q [$];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: samples well clear of the rising edge.
  always begin
    @(negedge clk);
    #2;
    if (mon_en && rst_n) begin
      if (stall_prev) begin
        check("hold_valid", DW'(bus.m_axis_tvalid), DW'(1));
        check("hold_data", bus.m_axis_tdata, stall_data);
      end
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %h expected none", bus.m_axis_tdata);
        end else begin
          check("word", bus.m_axis_tdata, exp_q.pop_front());
        end
      end
      stall_prev = bus.m_axis_tvalid & ~bus.m_axis_tready;
      stall_data = bus.m_axis_tdata;
      if (err_align) begin
        seen_err++;
        if (err_prev) begin
          checks++;
          errors++;
          $display("FAIL err_width: got 2+ cycles expected 1");
        end
      end
      err_prev = err_align;
    end else begin
      stall_prev = 1'b0;
      err_prev   = 1'b0;
    end
  end

  task automatic send_beat(input logic [CW-1:0] d, input logic l);
    int unsigned waited = 0;
    @(negedge clk);
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = d;
    bus.s_axis_tlast  = l;
    #1;
    while (!bus.s_axis_tready) begin
      stall_cnt++;
      if (waited == 50) begin
        checks++;
        errors++;
        $display("FAIL beat_timeout: got tready=0 for 50 cycles expected acceptance");
        break;
      end
      @(negedge clk);
      #1;
      waited++;
    end
    @(posedge clk);
  endtask

  task automatic send_word(input logic [CW-1:0] c0, input logic [CW-1:0] c1,
                           input logic [CW-1:0] c2, input logic [CW-1:0] c3,
                           input bit final_last);
    exp_q.push_back({c3, c2, c1, c0});
    if (!final_last) exp_err++;
    send_beat(c0, 1'b0);
    send_beat(c1, 1'b0);
    send_beat(c2, 1'b0);
    send_beat(c3, final_last);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.s_axis_tvalid = 1'b0;
      bus.s_axis_tlast  = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tlast  = 1'b0;
    bus.m_axis_tready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_m_tvalid", DW'(bus.m_axis_tvalid), DW'(0));
    check("rst_m_tdata", bus.m_axis_tdata, '0);
    check("rst_err", DW'(err_align), DW'(0));
    check("rst_s_tready", DW'(bus.s_axis_tready), DW'(1));
    mon_en = 1'b1;

    // Basic aligned word.
    send_word(64'h0000_0000_0000_0000, 64'h1111_1111_1111_1111,
              64'h2222_2222_2222_2222, 64'h3333_3333_3333_3333, 1'b1);
    idle(3);

    // Three back-to-back words at full rate.
    stall_cnt = 0;
    send_word(64'hA000_0000_0000_0000, 64'hA000_0000_0000_0001,
              64'hA000_0000_0000_0002, 64'hA000_0000_0000_0003, 1'b1);
    send_word(64'hB000_0000_0000_0010, 64'hB000_0000_0000_0011,
              64'hB000_0000_0000_0012, 64'hB000_0000_0000_0013, 1'b1);
    send_word(64'hC000_0000_0000_0020, 64'hC000_0000_0000_0021,
              64'hC000_0000_0000_0022, 64'hC000_0000_0000_0023, 1'b1);
    check("full_rate_stalls", DW'(stall_cnt), DW'(0));
    idle(3);

    // Back-pressure: word held for 10 cycles, next word's final beat stalls.
    @(negedge clk);
    bus.m_axis_tready = 1'b0;
    send_word(64'hD0D0_0000_0000_0000, 64'hD0D0_0000_0000_0001,
              64'hD0D0_0000_0000_0002, 64'hD0D0_0000_0000_0003, 1'b1);
    stall_cnt = 0;
    fork
      send_word(64'hE0E0_0000_0000_0000, 64'hE0E0_0000_0000_0001,
                64'hE0E0_0000_0000_0002, 64'hE0E0_0000_0000_0003, 1'b1);
      begin
        repeat (10) @(negedge clk);
        bus.m_axis_tready = 1'b1;
      end
    join
    check("backpressure_stalled", DW'(stall_cnt != 0), DW'(1));
    idle(3);

    // Early tlast: partial word dropped, then a clean word.
    send_beat(64'hDEAD_0000_0000_0000, 1'b0);
    send_beat(64'hDEAD_0000_0000_0001, 1'b1);
    exp_err++;
    send_word(64'h0F00_0000_0000_0000, 64'h0F00_0000_0000_0001,
              64'h0F00_0000_0000_0002, 64'h0F00_0000_0000_0003, 1'b1);
    idle(3);

    // Missing tlast: word still emitted; then reset mid-word.
    send_word(64'h5500_0000_0000_0000, 64'h5500_0000_0000_0001,
              64'h5500_0000_0000_0002, 64'h5500_0000_0000_0003, 1'b0);
    send_beat(64'hBAD0_0000_0000_0000, 1'b0);
    send_beat(64'hBAD0_0000_0000_0001, 1'b0);
    @(negedge clk);
    bus.s_axis_tvalid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_rst_m_tvalid", DW'(bus.m_axis_tvalid), DW'(0));
    check("mid_rst_err", DW'(err_align), DW'(0));
    check("mid_rst_s_tready", DW'(bus.s_axis_tready), DW'(1));
    send_word(64'h7700_0000_0000_0000, 64'h7700_0000_0000_0001,
              64'h7700_0000_0000_0002, 64'h7700_0000_0000_0003, 1'b1);
    idle(6);

    check("pending_words", DW'(exp_q.size()), DW'(0));
    check("err_pulses", DW'(seen_err), DW'(exp_err));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
